// File: rtl/controller_command_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : controller_command_rx_pkg                                    |
// | Description : Shared controller definitions: register map, status/ctrl    |
// |               bit positions and link byte width.                           |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package controller_command_rx_pkg;

  // Width of one command byte on the external link
  localparam int BYTE_W = 8;

  // Avalon-MM word address map
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_CLEAR  = 2'd3
  } reg_addr_e;

  // STATUS register layout
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 8;

  // CTRL register layout
  localparam int CTRL_IRQ_EN_BIT     = 0;
  localparam int CTRL_OVF_IRQ_EN_BIT = 1;

  // CLEAR register layout (write-only action bits)
  localparam int CLR_OVF_BIT   = 0;
  localparam int CLR_FLUSH_BIT = 1;

endpackage
`default_nettype wire

// File: rtl/controller_command_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : controller_command_rx_fifo                                   |
// | Description : Synchronous FIFO with first-word-fall-through head output.  |
// | Ports       : clk, reset_n (async, active-low)                             |
// |               push, wdata     - write request / data (ignored when full   |
// |                                 unless a pop happens in the same cycle)    |
// |               pop             - read request (ignored when empty)          |
// |               flush           - drop all contents, overrides push/pop      |
// |               head            - byte at the read pointer                   |
// |               count, full, empty - occupancy                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module controller_command_rx_fifo
  import controller_command_rx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              pop,
  input  logic              flush,
  output logic [BYTE_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A pop on a full FIFO frees the slot the simultaneous push needs
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head = mem[rd_ptr];

  // Storage is intentionally not reset; empty masks stale contents
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/controller_command_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : controller_command_rx                                        |
// | Description : Command byte receiver: buffers link bytes in a FIFO and     |
// |               exposes them through an Avalon-MM slave with status,        |
// |               interrupt control and overflow/flush handling.              |
// | Ports       : clk, reset_n (async, active-low)                             |
// |               in_data, in_valid - command byte strobe from the link       |
// |               address, chipselect, read_n, write_n, writedata - slave bus |
// |               readdata          - combinational read data (0 latency)     |
// |               irq               - registered level interrupt              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module controller_command_rx
  import controller_command_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [BYTE_W-1:0]       head;
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    empty;
  logic                    pop_req;
  logic                    wr_en;
  logic                    flush;
  logic                    ovf_clr;
  logic                    ovf_set;
  logic                    overflow;
  logic                    irq_en;
  logic                    ovf_irq_en;
  logic [STAT_COUNT_W-1:0] count_field;
  logic                    unused_wdata;

  assign pop_req = chipselect & ~read_n & (address == REG_DATA);
  assign wr_en   = chipselect & ~write_n;
  assign flush   = wr_en & (address == REG_CLEAR) & writedata[CLR_FLUSH_BIT];
  assign ovf_clr = wr_en & (address == REG_CLEAR) & writedata[CLR_OVF_BIT];

  // A byte is lost only when full and no pop frees a slot this cycle; a
  // deliberate flush discards it without flagging overflow.
  assign ovf_set = in_valid & full & ~pop_req & ~flush;

  assign unused_wdata = ^writedata[31:2];

  controller_command_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_valid),
    .wdata   (in_data),
    .pop     (pop_req),
    .flush   (flush),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      irq_en     <= 1'b0;
      ovf_irq_en <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (ovf_clr) begin
        overflow <= 1'b0;
      end else if (ovf_set) begin
        overflow <= 1'b1;
      end
      if (wr_en && (address == REG_CTRL)) begin
        irq_en     <= writedata[CTRL_IRQ_EN_BIT];
        ovf_irq_en <= writedata[CTRL_OVF_IRQ_EN_BIT];
      end
      // Sampled from current state, so irq trails the flag change by a cycle
      irq <= (irq_en & ~empty) | (ovf_irq_en & overflow);
    end
  end

  always_comb begin
    count_field = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (i < STAT_COUNT_W) count_field[i] = count[i];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA: begin
        if (!empty) readdata[BYTE_W-1:0] = head;
      end
      REG_STATUS: begin
        readdata[STAT_EMPTY_BIT]                      = empty;
        readdata[STAT_FULL_BIT]                       = full;
        readdata[STAT_OVF_BIT]                        = overflow;
        readdata[STAT_COUNT_LSB +: STAT_COUNT_W]      = count_field;
      end
      REG_CTRL: begin
        readdata[CTRL_IRQ_EN_BIT]     = irq_en;
        readdata[CTRL_OVF_IRQ_EN_BIT] = ovf_irq_en;
      end
      default: readdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_controller_command_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_controller_command_rx                                     |
// | Description : Scoreboard bench for controller_command_rx. Stimulus queues  |
// |               the expected readdata (and optionally irq) for every bus    |
// |               read; a monitor compares them mid-cycle.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_controller_command_rx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  string       name_q [$];
  logic [31:0] data_q [$];
  bit          ci_q   [$];
  bit          irq_q  [$];

  always #5 clk = ~clk;

  controller_command_rx #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  // Status word: empty bit0, full bit1, overflow bit2, count bits[15:8]
  function automatic logic [31:0] st(input bit e, input bit f, input bit o, input int c);
    logic [31:0] v;
    v = 32'(c) << 8;
    v[0] = e;
    v[1] = f;
    v[2] = o;
    return v;
  endfunction

  // Monitor: every read strobe pops one expectation
  string       m_name;
  logic [31:0] m_data;
  bit          m_ci;
  bit          m_irq;
  always @(negedge clk) begin
    if (chipselect && !read_n) begin
      n_checks++;
      if (data_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: readdata=0x%08h, no expectation queued", readdata);
      end else begin
        m_name = name_q.pop_front();
        m_data = data_q.pop_front();
        m_ci   = ci_q.pop_front();
        m_irq  = irq_q.pop_front();
        if (readdata !== m_data) begin
          n_fail++;
          $display("FAIL %s: readdata=0x%08h expected 0x%08h", m_name, readdata, m_data);
        end
        if (m_ci) begin
          n_checks++;
          if (irq !== m_irq) begin
            n_fail++;
            $display("FAIL %s_irq: irq=%0b expected %0b", m_name, irq, m_irq);
          end
        end
      end
    end
  end

  // One bus/link cycle, driven just after a rising edge
  task automatic cyc(input bit v, input logic [7:0] d, input bit rd, input bit wr,
                     input logic [1:0] a, input logic [31:0] wd, input string nm,
                     input logic [31:0] exp, input bit ci, input bit ei);
    in_valid   = v;
    in_data    = d;
    chipselect = rd | wr;
    read_n     = ~rd;
    write_n    = ~wr;
    address    = a;
    writedata  = wd;
    if (rd) begin
      name_q.push_back(nm);
      data_q.push_back(exp);
      ci_q.push_back(ci);
      irq_q.push_back(ei);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 2'd0, 32'h0, "", 32'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, a, 32'h0, nm, exp, 1'b0, 1'b0);
  endtask

  task automatic rdi(input logic [1:0] a, input logic [31:0] exp, input bit ei, input string nm);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, a, 32'h0, nm, exp, 1'b1, ei);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, a, d, "", 32'h0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, "", 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;
    @(posedge clk);
    #1;

    // Reset state
    rd (2'd0, 32'h0, "rst_data");
    rdi(2'd1, st(1, 0, 0, 0), 1'b0, "rst_status");
    rd (2'd2, 32'h0, "rst_ctrl");
    rd (2'd3, 32'h0, "rst_clear_reads0");
    reset_n = 1'b1;
    idle();

    // Basic push/pop, ignored writes, empty read
    push(8'hA5);
    push(8'h3C);
    rd(2'd1, st(0, 0, 0, 2), "count2");
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, st(0, 0, 0, 2), "ignored_writes");
    rd(2'd0, 32'hA5, "pop_A5");
    rd(2'd0, 32'h3C, "pop_3C");
    rd(2'd1, st(1, 0, 0, 0), "empty_after_pops");
    rd(2'd0, 32'h0, "empty_read");
    rd(2'd1, st(1, 0, 0, 0), "empty_read_noflag");
    push(8'h5A);
    rd(2'd0, 32'h5A, "latency1");

    // Overflow at depth 8
    for (int i = 1; i <= 9; i++) push(8'(i));
    rd(2'd1, st(0, 1, 1, 8), "full_ovf");
    for (int i = 1; i <= 8; i++) rd(2'd0, 32'(i), "ovf_drain");
    rd(2'd1, st(1, 0, 1, 0), "ovf_sticky");
    rd(2'd0, 32'h0, "byte9_lost");
    wr(2'd3, 32'h1);
    rd(2'd1, st(1, 0, 0, 0), "ovf_cleared");

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    rd(2'd1, st(0, 1, 0, 8), "full_no_ovf");
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 2'd0, 32'h0, "pushpop_full", 32'h20, 1'b0, 1'b0);
    rd(2'd1, st(0, 1, 0, 8), "pushpop_count8");
    for (int i = 1; i < 8; i++) rd(2'd0, 32'h20 + 32'(i), "pushpop_drain");
    rd(2'd0, 32'h55, "pushpop_last55");
    rd(2'd1, st(1, 0, 0, 0), "pushpop_empty");

    // CTRL register and data-available interrupt
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 32'h3, "ctrl_rw");
    wr(2'd2, 32'h1);
    rd(2'd2, 32'h1, "ctrl_irq_en");
    push(8'h10);
    rdi(2'd1, st(0, 0, 0, 1), 1'b0, "irq_lag");
    rdi(2'd1, st(0, 0, 0, 1), 1'b1, "irq_set");
    rdi(2'd0, 32'h10, 1'b1, "irq_pop10");
    rdi(2'd1, st(1, 0, 0, 0), 1'b1, "irq_fall_lag");
    rdi(2'd1, st(1, 0, 0, 0), 1'b0, "irq_clear");
    wr(2'd2, 32'h0);

    // Overflow interrupt, clear + flush
    wr(2'd2, 32'h2);
    for (int i = 0; i < 9; i++) push(8'h30 + 8'(i));
    rdi(2'd1, st(0, 1, 1, 8), 1'b0, "ovf_irq_lag");
    rdi(2'd1, st(0, 1, 1, 8), 1'b1, "ovf_irq_set");
    wr(2'd3, 32'h3);
    rdi(2'd1, st(1, 0, 0, 0), 1'b1, "flush_irq_lag");
    rdi(2'd1, st(1, 0, 0, 0), 1'b0, "flush_irq_drop");
    push(8'h40);
    push(8'h41);
    cyc(1'b1, 8'h42, 1'b0, 1'b1, 2'd3, 32'h2, "", 32'h0, 1'b0, 1'b0);
    rd(2'd1, st(1, 0, 0, 0), "flush_over_push");
    rd(2'd0, 32'h0, "flush_data0");
    wr(2'd2, 32'h0);

    // Reset in mid-operation
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    wr(2'd2, 32'h1);
    idle();
    rdi(2'd1, st(0, 0, 0, 5), 1'b1, "pre_rst_count5");
    reset_n = 1'b0;
    rdi(2'd1, st(1, 0, 0, 0), 1'b0, "mid_rst_status");
    rd(2'd2, 32'h0, "mid_rst_ctrl");
    rd(2'd0, 32'h0, "mid_rst_data");
    reset_n = 1'b1;
    push(8'h77);
    rd(2'd0, 32'h77, "post_rst_77");
    rd(2'd1, st(1, 0, 0, 0), "post_rst_empty");

    idle();
    idle();
    n_checks++;
    if (data_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", data_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controller_command_rx.md
CONTROLLER_COMMAND_RX -- requirements
Module: controller_command_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries; must be a power of 2, min 2.
REQ-002 SHALL have port clk, input, 1, meaning system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n, input, 1, meaning reset, asynchronous, active-low.
REQ-004 SHALL have port in_data, input, 8, meaning command byte from external link, synchronous to clk.
REQ-005 SHALL have port in_valid, input, 1, meaning one-cycle strobe: in_data valid this cycle.
REQ-006 SHALL have port address, input, 2, meaning Avalon-MM slave word address.
REQ-007 SHALL have port chipselect, input, 1, meaning slave select.
REQ-008 SHALL have port read_n, input, 1, meaning active-low read strobe, one cycle per access.
REQ-009 SHALL have port write_n, input, 1, meaning active-low write strobe.
REQ-010 SHALL have port writedata, input, 32, meaning write data.
REQ-011 SHALL have port readdata, output, 32, meaning read data, combinational, zero read latency.
REQ-012 SHALL have port irq, output, 1, meaning level interrupt, active-high.

Function
REQ-013 SHALL write in_data into the FIFO tail on in_valid=1 when not full; count increments.
REQ-014 SHALL discard in_data on in_valid=1 when full, set sticky overflow=1, and leave FIFO contents unchanged.
REQ-015 SHALL present readdata = {24'b0, head byte} at address 0; readdata = 0 when empty.
REQ-016 SHALL pop the head on chipselect=1, read_n=0, address=0 when non-empty; a read when empty has no effect and sets no flag.
REQ-017 SHALL handle push and pop in the same cycle: full -> push accepted, no overflow; empty -> pop ignored, push accepted; count unchanged when both take effect.
REQ-018 SHALL present at address 1: bit0 empty, bit1 full, bit2 overflow, bits[15:8] count (0..FIFO_DEPTH), other bits 0.
REQ-019 SHALL present at address 2: bit0 irq_en, bit1 ovf_irq_en; both writable through writedata[1:0].
REQ-020 SHALL clear overflow on write to address 3 with writedata[0]=1; bit1=1 SHALL flush the FIFO (count=0) in the same cycle; a flush overrides a simultaneous push.
REQ-021 SHALL return 0 on reads of address 3; writes to addresses 0 and 1 SHALL be ignored.
REQ-022 SHALL make read and write pointers wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-023 SHALL drive irq = (irq_en & ~empty) | (ovf_irq_en & overflow) as a registered output, updated one cycle after the state change.
REQ-024 SHALL make a pushed byte readable at address 0 on the cycle after in_valid (1-cycle latency).

Reset
REQ-025 SHALL, on reset_n=0, immediately set pointers=0, count=0, overflow=0, irq_en=0, ovf_irq_en=0, irq=0; readdata at address 0 SHALL read 0.
REQ-026 SHALL NOT reset FIFO storage RAM; the empty flag SHALL mask stale data.
REQ-027 SHALL lose all buffered data when reset asserts mid-operation; the first in_valid after release SHALL be accepted normally.

Structure
REQ-028 SHALL take the register address constants (DATA=0, STATUS=1, CTRL=2, CLEAR=3), status/ctrl bit positions, and the byte width from the shared controller package.
REQ-029 SHALL place the synchronous FIFO (storage, pointers, count, full/empty) in one sub-module, controller_command_rx_fifo; the top level holds register decode, flags and irq.

Verification
REQ-030 SHALL cover push 0xA5, 0x3C -> status count=2; reads at address 0 return 0xA5 then 0x3C; then empty=1.
REQ-031 SHALL cover 9 pushes 0x01..0x09 at depth 8 -> full=1, overflow=1; reads return 0x01..0x08; 0x09 is lost.
REQ-032 SHALL cover full FIFO with simultaneous push 0x55 and pop -> overflow stays 0, count stays 8; last read returns 0x55.
REQ-033 SHALL cover irq_en=1 on empty FIFO, push 0x10 -> irq=1 one cycle later; read 0x10 -> irq=0 the next cycle.
REQ-034 SHALL cover overflow set, write 0x3 to address 3 -> overflow=0, count=0, empty=1, and irq drops if only ovf_irq_en was set.
REQ-035 SHALL cover reset_n pulsed low with count=5 -> count=0 and irq=0 immediately; post-release push 0x77 is read back as 0x77.
